// File: rtl/back1_ctrl_pkg.sv
// Shared types and constants for the Back1 background-layer VRAM arbiter.
package back1_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2,
    ST_HOLD   = 2'd3
  } arb_state_e;

  localparam int PH_W = 3;

  localparam int DEF_ADDR_W       = 13;
  localparam int DEF_VIDEO_PHASES = 4;
  localparam int DEF_VLK_PHASE    = 1;
  localparam int DEF_LA_PHASE     = 3;

  localparam int          SCROLL_W = 9;
  localparam logic [7:0]  VD_IDLE  = 8'hFF;

endpackage

// File: rtl/back1_scroll_shadow.sv
// Holds CPU scroll writes and replays them onto the shared VD bus at line start:
// Y in the first clk after line_start, X in the second.
module back1_scroll_shadow
  import back1_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                line_start,
  input  logic                sx_wr,
  input  logic                sy_wr,
  input  logic [SCROLL_W-1:0] scroll_d,
  output logic                b1sx,
  output logic                b1sy,
  output logic [7:0]          scroll_vd,
  output logic                b1x8,
  output logic                b1y8
);

  logic [SCROLL_W-1:0] y_q, x_q, snap_x_q;
  logic                pend_y_q, pend_x_q, snap_v_q, slot2_q;
  logic                sy_q, sx_q, y8_q, x8_q;
  logic [7:0]          vd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= '0;
      x_q      <= '0;
      snap_x_q <= '0;
      pend_y_q <= 1'b0;
      pend_x_q <= 1'b0;
      snap_v_q <= 1'b0;
      slot2_q  <= 1'b0;
      sy_q     <= 1'b0;
      sx_q     <= 1'b0;
      y8_q     <= 1'b0;
      x8_q     <= 1'b0;
      vd_q     <= VD_IDLE;
    end else begin
      sy_q    <= 1'b0;
      sx_q    <= 1'b0;
      vd_q    <= VD_IDLE;
      slot2_q <= 1'b0;
      // X is snapshotted at line_start so writes landing in the apply window wait a line
      if (line_start) begin
        slot2_q  <= 1'b1;
        snap_v_q <= pend_x_q;
        snap_x_q <= x_q;
        if (pend_y_q) begin
          sy_q <= 1'b1;
          vd_q <= y_q[7:0];
          y8_q <= y_q[8];
        end
      end else if (slot2_q && snap_v_q) begin
        sx_q <= 1'b1;
        vd_q <= snap_x_q[7:0];
        x8_q <= snap_x_q[8];
      end
      pend_y_q <= sy_wr | (pend_y_q & ~line_start);
      pend_x_q <= sx_wr | (pend_x_q & ~line_start);
      if (sy_wr) y_q <= scroll_d;
      if (sx_wr) x_q <= scroll_d;
    end
  end

  assign b1sy      = sy_q;
  assign b1sx      = sx_q;
  assign scroll_vd = vd_q;
  assign b1y8      = y8_q;
  assign b1x8      = x8_q;

endmodule

// File: rtl/back1_vram_arbiter.sv
// Back1 tile-period sequencer: video-fetch strobes, CPU access windows with a
// req/ack handshake, and line-start scroll register loading.
module back1_vram_arbiter
  import back1_ctrl_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int VIDEO_PHASES = DEF_VIDEO_PHASES,
  parameter int VLK_PHASE    = DEF_VLK_PHASE,
  parameter int LA_PHASE     = DEF_LA_PHASE
) (
  input  logic              clk,
  input  logic              VIDEO_RSTn,
  input  logic              pix_ce,
  input  logic              line_start,
  input  logic              hblank,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic              V_C,
  output logic              VLK,
  output logic              LA,
  output logic              vram_cen,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_q,
  input  logic              sx_wr,
  input  logic              sy_wr,
  input  logic [8:0]        scroll_d,
  output logic              B1SX,
  output logic              B1SY,
  output logic [7:0]        scroll_vd,
  output logic              B1X8,
  output logic              B1Y8
);

  localparam logic [PH_W-1:0] VID_END = PH_W'(VIDEO_PHASES);
  localparam logic [PH_W-1:0] VLK_PH  = PH_W'(VLK_PHASE);
  localparam logic [PH_W-1:0] LA_PH   = PH_W'(LA_PHASE);
  localparam logic [PH_W-1:0] PH_LAST = {PH_W{1'b1}};

  logic [PH_W-1:0] ph_q, ph_d;
  arb_state_e      state_q, state_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            video_ce;
  logic            grant;

  always_comb begin
    ph_d = ph_q;
    if (line_start)  ph_d = '0;
    else if (pix_ce) ph_d = ph_q + 1'b1;
  end

  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      ph_q    <= '0;
      state_q <= ST_IDLE;
      rdata_q <= 8'hFF;
    end else begin
      ph_q    <= ph_d;
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign video_ce = pix_ce & ~hblank;
  assign VLK      = video_ce & (ph_q == VLK_PH);
  assign LA       = video_ce & (ph_q == LA_PH);
  assign V_C      = hblank | (ph_q >= VID_END);

  // A grant on the last phase edge would put the access into phase 0 of the next tile.
  assign grant = V_C & ~line_start & ~(video_ce & (ph_q == PH_LAST));

  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    cpu_rdata  = rdata_q;
    cpu_ack    = 1'b0;
    vram_cen   = 1'b0;
    vram_we    = 1'b0;
    vram_addr  = '0;
    vram_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && grant) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        vram_cen   = 1'b1;
        vram_we    = cpu_we;
        vram_addr  = cpu_addr;
        vram_wdata = cpu_wdata;
        state_d    = ST_ACK;
      end
      ST_ACK: begin
        cpu_ack = 1'b1;
        if (!cpu_we) begin
          rdata_d   = vram_q;
          cpu_rdata = vram_q;
        end
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!cpu_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cpu_wait = cpu_req & ((state_q == ST_IDLE) | (state_q == ST_ACCESS));

  back1_scroll_shadow u_scroll (
    .clk        (clk),
    .rst_n      (VIDEO_RSTn),
    .line_start (line_start),
    .sx_wr      (sx_wr),
    .sy_wr      (sy_wr),
    .scroll_d   (scroll_d),
    .b1sx       (B1SX),
    .b1sy       (B1SY),
    .scroll_vd  (scroll_vd),
    .b1x8       (B1X8),
    .b1y8       (B1Y8)
  );

endmodule

// File: tb/tb_back1_vram_arbiter.sv
// Self-checking bench for back1_vram_arbiter: transaction-level reference model
// checked every cycle plus directed literal expectations.
module tb_back1_vram_arbiter;

  logic        clk = 1'b0;
  logic        VIDEO_RSTn, pix_ce, line_start, hblank;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack, cpu_wait, V_C, VLK, LA;
  logic        vram_cen, vram_we;
  logic [12:0] vram_addr;
  logic [7:0]  vram_wdata, vram_q;
  logic        sx_wr, sy_wr;
  logic [8:0]  scroll_d;
  logic        B1SX, B1SY, B1X8, B1Y8;
  logic [7:0]  scroll_vd;

  always #5 clk = ~clk;

  back1_vram_arbiter dut (
    .clk(clk), .VIDEO_RSTn(VIDEO_RSTn), .pix_ce(pix_ce), .line_start(line_start),
    .hblank(hblank), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .V_C(V_C), .VLK(VLK), .LA(LA), .vram_cen(vram_cen), .vram_we(vram_we),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_q(vram_q),
    .sx_wr(sx_wr), .sy_wr(sy_wr), .scroll_d(scroll_d), .B1SX(B1SX), .B1SY(B1SY),
    .scroll_vd(scroll_vd), .B1X8(B1X8), .B1Y8(B1Y8)
  );

  // Synchronous VRAM, 1-clk read latency
  logic [7:0] ram [0:8191];
  always @(posedge clk) begin
    if (vram_cen) begin
      if (vram_we) ram[vram_addr] <= vram_wdata;
      vram_q <= ram[vram_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       sy;
    logic       sx;
    logic [7:0] vd;
    logic       b8;
  } slot_t;

  int          cyc = 0;
  int          m_ph = 0;
  bit          m_granted = 0, m_await = 0;
  int          m_acc = 0, m_ack = 0;
  logic [12:0] m_addr = '0;
  bit          m_we = 0;
  logic [7:0]  m_wd = '0;
  logic [7:0]  m_rdata = 8'hFF;
  logic [7:0]  ref_mem [0:8191];
  bit          py_v = 0, px_v = 0;
  logic [8:0]  py = '0, px = '0;
  logic        m_y8 = 0, m_x8 = 0;
  slot_t       sq[$];

  always @(negedge clk) begin : cmp
    slot_t      head;
    bit         e_vc, e_vlk, e_la, e_cen, e_ack, e_wait, g;
    logic [7:0] e_rd;
    if (!VIDEO_RSTn) begin
      m_ph = 0; m_granted = 0; m_await = 0; m_rdata = 8'hFF;
      py_v = 0; px_v = 0; m_y8 = 0; m_x8 = 0;
      sq.delete();
    end
    cyc++;
    e_vc   = hblank || (m_ph >= 4);
    e_vlk  = pix_ce && !hblank && (m_ph == 1);
    e_la   = pix_ce && !hblank && (m_ph == 3);
    e_cen  = m_granted && (cyc == m_acc);
    e_ack  = m_granted && (cyc == m_ack);
    e_wait = cpu_req && !((m_granted && cyc >= m_ack) || m_await);
    e_rd   = m_rdata;
    if (e_ack && !m_we) e_rd = ref_mem[m_addr];

    chk("V_C", 32'(V_C), 32'(e_vc));
    chk("VLK", 32'(VLK), 32'(e_vlk));
    chk("LA", 32'(LA), 32'(e_la));
    chk("vram_cen", 32'(vram_cen), 32'(e_cen));
    chk("cpu_ack", 32'(cpu_ack), 32'(e_ack));
    chk("cpu_wait", 32'(cpu_wait), 32'(e_wait));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rd));
    if (e_cen) begin
      chk("vram_addr", 32'(vram_addr), 32'(m_addr));
      chk("vram_we", 32'(vram_we), 32'(m_we));
      if (m_we) chk("vram_wdata", 32'(vram_wdata), 32'(m_wd));
    end else begin
      chk("vram_we_idle", 32'(vram_we), 32'h0);
    end
    if (vram_cen) chk("cen_in_window", 32'(V_C), 32'h1);

    head = '{sy: 1'b0, sx: 1'b0, vd: 8'hFF, b8: 1'b0};
    if (sq.size() > 0) head = sq[0];
    if (head.sy) m_y8 = head.b8;
    if (head.sx) m_x8 = head.b8;
    chk("B1SY", 32'(B1SY), 32'(head.sy));
    chk("B1SX", 32'(B1SX), 32'(head.sx));
    chk("scroll_vd", 32'(scroll_vd), 32'(head.vd));
    chk("B1Y8", 32'(B1Y8), 32'(m_y8));
    chk("B1X8", 32'(B1X8), 32'(m_x8));

    if (VIDEO_RSTn) begin
      g = (hblank || m_ph >= 4) && !line_start && !(pix_ce && m_ph == 7 && !hblank);
      if (e_ack) begin
        if (m_we) ref_mem[m_addr] = m_wd;
        else      m_rdata = e_rd;
        m_granted = 0;
        m_await   = 1;
      end else if (m_await) begin
        if (!cpu_req) m_await = 0;
      end else if (!m_granted && cpu_req && g) begin
        m_granted = 1;
        m_acc = cyc + 1;
        m_ack = cyc + 2;
        m_addr = cpu_addr;
        m_we = cpu_we;
        m_wd = cpu_wdata;
      end
      if (line_start)  m_ph = 0;
      else if (pix_ce) m_ph = (m_ph + 1) % 8;
      if (sq.size() > 0) void'(sq.pop_front());
      if (line_start) begin
        sq.push_back('{sy: py_v, sx: 1'b0, vd: (py_v ? py[7:0] : 8'hFF), b8: py[8]});
        sq.push_back('{sy: 1'b0, sx: px_v, vd: (px_v ? px[7:0] : 8'hFF), b8: px[8]});
        py_v = 0;
        px_v = 0;
      end
      if (sy_wr) begin py = scroll_d; py_v = 1; end
      if (sx_wr) begin px = scroll_d; px_v = 1; end
    end
  end

  // ---------------- stimulus ----------------
  int div = 0;

  task automatic step();
    @(posedge clk);
    #1;
    pix_ce = (div == 3);
    div = (div + 1) % 4;
  endtask

  task automatic next();
    @(negedge clk);
    step();
  endtask

  task automatic run(input int k);
    repeat (k) next();
  endtask

  task automatic do_line_start();
    next();
    line_start = 1'b1;
    pix_ce = 1'b0;
    div = 0;
    next();
    line_start = 1'b0;
  endtask

  task automatic cpu_txn(input bit we, input logic [12:0] a, input logic [7:0] d,
                         input int hold, output int n, output logic [7:0] rd,
                         output int extra);
    bit got;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    n = 0; rd = '0; extra = 0; got = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (cpu_ack === 1'b1) begin
        got = 1;
        rd = cpu_rdata;
      end else begin
        step();
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack, expected ack within 300 clks");
    end
    for (int i = 0; i < hold; i++) begin
      step();
      @(negedge clk);
      extra += int'(vram_cen);
    end
    step();
    cpu_req = 1'b0;
    step();
  endtask

  int          n, extra, vlk_n, la_n, vc_n, bad;
  logic [7:0]  rd;

  initial begin
    VIDEO_RSTn = 1'b0; pix_ce = 1'b0; line_start = 1'b0; hblank = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    sx_wr = 1'b0; sy_wr = 1'b0; scroll_d = '0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;

    // Reset values
    @(negedge clk); #1;
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'hFF);
    chk("rst_scroll_vd", 32'(scroll_vd), 32'hFF);
    chk("rst_V_C", 32'(V_C), 32'h0);
    hblank = 1'b1; #1;
    chk("rst_V_C_hblank", 32'(V_C), 32'h1);
    hblank = 1'b0;
    step();
    VIDEO_RSTn = 1'b1;
    $display("reset released");

    // Two tile periods of video strobes
    do_line_start();
    vlk_n = 0; la_n = 0; vc_n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      vlk_n += int'(VLK); la_n += int'(LA); vc_n += int'(V_C);
      step();
    end
    chk("vlk_count", 32'(vlk_n), 32'd2);
    chk("la_count", 32'(la_n), 32'd2);
    chk("vc_count", 32'(vc_n), 32'd32);
    $display("video: vlk=%0d la=%0d vc_cycles=%0d", vlk_n, la_n, vc_n);

    // hblank accesses: 2-clk completion regardless of phase
    hblank = 1'b1;
    cpu_txn(1'b1, 13'h1FFF, 8'h5A, 3, n, rd, extra);
    chk("hb_write_lat", 32'(n), 32'd3);
    chk("hold_no_second_cen", 32'(extra), 32'd0);
    $display("write 1FFF<=5A lat=%0d extra_cen=%0d", n, extra);
    cpu_txn(1'b1, 13'h00A5, 8'h3C, 0, n, rd, extra);
    chk("hb_write2_lat", 32'(n), 32'd3);
    $display("write 00A5<=3C lat=%0d", n);
    cpu_txn(1'b1, 13'h0010, 8'h11, 0, n, rd, extra);
    $display("write 0010<=11 lat=%0d", n);
    cpu_txn(1'b0, 13'h1FFF, 8'h00, 0, n, rd, extra);
    chk("hb_read_lat", 32'(n), 32'd3);
    chk("hb_readback", 32'(rd), 32'h5A);
    $display("read 1FFF lat=%0d data=%0h", n, rd);

    // Read raised at phase 0: deferred to phase 4
    hblank = 1'b0;
    do_line_start();
    cpu_txn(1'b0, 13'h00A5, 8'h00, 0, n, rd, extra);
    chk("ph0_read_lat", 32'(n), 32'd19);
    chk("ph0_read_data", 32'(rd), 32'h3C);
    $display("read 00A5 from ph0 lat=%0d data=%0h", n, rd);

    // Request arriving with pix_ce at phase 7: deferred into next period
    do_line_start();
    run(31);
    cpu_txn(1'b0, 13'h1FFF, 8'h00, 0, n, rd, extra);
    chk("ph7_defer_lat", 32'(n), 32'd20);
    chk("ph7_defer_data", 32'(rd), 32'h5A);
    $display("read 1FFF from ph7 edge lat=%0d data=%0h", n, rd);

    // Scroll shadow: last Y write wins, then X
    next(); sy_wr = 1'b1; scroll_d = 9'h1F0;
    next(); scroll_d = 9'h005;
    next(); sy_wr = 1'b0; sx_wr = 1'b1; scroll_d = 9'h123;
    next(); sx_wr = 1'b0;
    do_line_start();
    @(negedge clk);
    chk("slot1_B1SY", 32'(B1SY), 32'h1);
    chk("slot1_vd", 32'(scroll_vd), 32'h05);
    chk("slot1_B1Y8", 32'(B1Y8), 32'h0);
    chk("slot1_B1SX", 32'(B1SX), 32'h0);
    step(); @(negedge clk);
    chk("slot2_B1SX", 32'(B1SX), 32'h1);
    chk("slot2_vd", 32'(scroll_vd), 32'h23);
    chk("slot2_B1X8", 32'(B1X8), 32'h1);
    chk("slot2_B1SY", 32'(B1SY), 32'h0);
    step(); @(negedge clk);
    chk("post_vd_idle", 32'(scroll_vd), 32'hFF);
    $display("scroll line applied Y=005 X=123");
    step();

    // X write coinciding with line_start waits a line
    next(); line_start = 1'b1; pix_ce = 1'b0; div = 0; sx_wr = 1'b1; scroll_d = 9'h0AA;
    next(); line_start = 1'b0; sx_wr = 1'b0;
    @(negedge clk); chk("coinc_slot1_B1SY", 32'(B1SY), 32'h0);
    step(); @(negedge clk); chk("coinc_slot2_B1SX", 32'(B1SX), 32'h0);
    step();
    do_line_start();
    @(negedge clk); chk("xonly_slot1_B1SY", 32'(B1SY), 32'h0);
    step(); @(negedge clk);
    chk("xonly_slot2_B1SX", 32'(B1SX), 32'h1);
    chk("xonly_slot2_vd", 32'(scroll_vd), 32'hAA);
    chk("xonly_slot2_B1X8", 32'(B1X8), 32'h0);
    $display("scroll X=0AA deferred one line then applied");
    step();

    // Reset during the ACCESS clk of a write, with a Y scroll pending
    hblank = 1'b1;
    next(); sy_wr = 1'b1; scroll_d = 9'h1FF;
    next(); sy_wr = 1'b0;
    cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 8'h77; cpu_req = 1'b1;
    @(negedge clk); step();
    @(negedge clk);
    chk("access_before_reset", 32'(vram_cen), 32'h1);
    #1;
    VIDEO_RSTn = 1'b0; cpu_req = 1'b0;
    #1;
    chk("async_rst_cen", 32'(vram_cen), 32'h0);
    chk("async_rst_we", 32'(vram_we), 32'h0);
    chk("async_rst_rdata", 32'(cpu_rdata), 32'hFF);
    chk("async_rst_ack", 32'(cpu_ack), 32'h0);
    chk("async_rst_vd", 32'(scroll_vd), 32'hFF);
    step(); step();
    VIDEO_RSTn = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bad += int'(vram_cen) + int'(vram_we);
      step();
    end
    chk("post_rst_quiet", 32'(bad), 32'd0);
    do_line_start();
    @(negedge clk); chk("post_rst_no_B1SY", 32'(B1SY), 32'h0);
    step(); @(negedge clk); chk("post_rst_no_B1SX", 32'(B1SX), 32'h0);
    step();
    cpu_txn(1'b0, 13'h0010, 8'h00, 0, n, rd, extra);
    chk("aborted_write_lat", 32'(n), 32'd3);
    chk("aborted_write_absent", 32'(rd), 32'h11);
    $display("read 0010 after aborted write data=%0h", rd);

    run(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
